// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port.
// Port A (ALU) wins by default; a starvation counter forces port B through after STARVE_MAX losses.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              b_forced
);

    // state | meaning
    // PRI_A | A has priority; cnt counts consecutive B losses
    // PRI_B | B is forced through this cycle if it is valid
    typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state, state_nx;
    logic   [3:0]      cnt, cnt_nx;
    logic              grant_any;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PRI_A;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            PRI_A: begin
                if (a_valid) begin
                    a_ready = 1'b1;
                    if (b_valid) begin
                        cnt_nx = (cnt == STARVE_LIM) ? STARVE_LIM : cnt + 4'd1;
                        if (cnt_nx == STARVE_LIM) state_nx = PRI_B;
                    end else begin
                        cnt_nx = 4'd0;
                    end
                end else begin
                    // B is either granted or not waiting, so it has not lost anything
                    cnt_nx  = 4'd0;
                    b_ready = b_valid;
                end
            end
            PRI_B: begin
                state_nx = PRI_A;
                cnt_nx   = 4'd0;
                if (b_valid) b_ready = 1'b1;
                else         a_ready = a_valid;
            end
            default: begin
                state_nx = PRI_A;
                cnt_nx   = 4'd0;
            end
        endcase
        if (!rst_n) begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end
    end

    assign grant_any = a_ready | b_ready;
    assign win_rd    = b_ready ? b_rd   : a_rd;
    assign win_data  = b_ready ? b_data : a_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            // x0 writes still complete the handshake but never reach the register file
            rf_we <= grant_any && (win_rd != '0);
            if (grant_any) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_data;
            end
        end
    end

    assign b_forced = (state == PRI_B);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected register-file writes are queued
// when a grant is predicted and compared when the output register presents them.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        b_forced;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    int          checks;
    int          errors;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .b_ready (b_ready),
        .rf_we   (rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .b_forced(b_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One arbitration cycle: drive, check readies, queue the predicted write,
    // then after the edge pop and compare the output register and b_forced.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                        input logic exp_ar, input logic exp_br, input logic exp_bf,
                        input string tag);
        exp_t e;
        @(negedge clk);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        #1;
        chk({tag, ".a_ready"}, 32'(a_ready), 32'(exp_ar));
        chk({tag, ".b_ready"}, 32'(b_ready), 32'(exp_br));
        if (exp_ar) begin
            e.we = (ard != 5'd0); e.addr = ard; e.data = ad;
        end else if (exp_br) begin
            e.we = (brd != 5'd0); e.addr = brd; e.data = bd;
        end else begin
            e.we = 1'b0; e.addr = last_addr; e.data = last_data;
        end
        last_addr = e.addr;
        last_data = e.data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s.scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".rf_we"},    32'(rf_we),    32'(e.we));
            chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(e.addr));
            chk({tag, ".rf_wdata"}, rf_wdata,      e.data);
        end
        chk({tag, ".b_forced"}, 32'(b_forced), 32'(exp_bf));
    endtask

    initial begin
        checks = 0; errors = 0;
        last_addr = 5'd0; last_data = 32'd0;
        rst_n = 1'b0;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h1111_0005;
        b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h2222_0006;

        // reset held with both sources requesting
        repeat (3) @(posedge clk);
        #1;
        chk("rst.a_ready",  32'(a_ready),  32'd0);
        chk("rst.b_ready",  32'(b_ready),  32'd0);
        chk("rst.rf_we",    32'(rf_we),    32'd0);
        chk("rst.rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst.rf_wdata", rf_wdata,      32'd0);
        chk("rst.b_forced", 32'(b_forced), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 5'd5, 32'h1111_0005, 1'b1, 5'd6, 32'h2222_0006, 1'b1, 1'b0, 1'b0, "first");

        // single A write, then idle: write must drop, address/data hold
        step(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, "single_a");
        step(1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, "idle");

        // starvation: four A wins, then B forced, then A resumes
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b1, 5'd3, 32'h55,
                 1'b1, 1'b0, (i == 3), $sformatf("starve%0d", i));
        step(1'b1, 5'd20, 32'hA000_0020, 1'b1, 5'd3, 32'h55, 1'b0, 1'b1, 1'b0, "forced_b");
        step(1'b1, 5'd20, 32'hA000_0020, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, "a_resume");

        // x0 write via B: handshake completes, no register-file write
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b0, "x0");

        // back-to-back alternation without bubbles
        step(1'b1, 5'd1, 32'h0000_0101, 1'b0, 5'd0, 32'd0,        1'b1, 1'b0, 1'b0, "alt1");
        step(1'b0, 5'd0, 32'd0,         1'b1, 5'd2, 32'h0000_0202, 1'b0, 1'b1, 1'b0, "alt2");
        step(1'b1, 5'd3, 32'h0000_0303, 1'b0, 5'd0, 32'd0,        1'b1, 1'b0, 1'b0, "alt3");
        step(1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,        1'b0, 1'b0, 1'b0, "alt_idle");

        // mid-operation reset drops the captured write of x9
        @(negedge clk);
        a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h9999_9999;
        b_valid = 1'b0;
        #1;
        chk("mid.a_ready", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mid.captured_we", 32'(rf_we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid.rf_we",    32'(rf_we),    32'd0);
        chk("mid.rf_waddr", 32'(rf_waddr), 32'd0);
        chk("mid.rf_wdata", rf_wdata,      32'd0);
        chk("mid.a_ready",  32'(a_ready),  32'd0);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.after_we",    32'(rf_we),    32'd0);
        chk("mid.after_waddr", 32'(rf_waddr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
